// File: rtl/event_blinker.sv
// event_blinker
//   Turns one-tick event pulses into LED blinks. Each accepted event gives one
//   blink: ON_TIME cycles lit, then OFF_TIME cycles dark. Events that arrive
//   while a blink is running are queued in a saturating pending counter. Each
//   queued event later gives its own blink, so fast presses stay separate.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ev       event pulse, one tick per event
//   clr      synchronous clear of the pending queue (running blink completes)
//   led      registered LED drive, high only while in ON
//   busy     high while a blink runs or events are queued
//   pending  number of queued events not yet started
//   ovf      one-cycle pulse when an event is dropped because the queue is full
module event_blinker #(
  parameter int unsigned ON_TIME  = 10_000_000,
  parameter int unsigned OFF_TIME = 10_000_000,
  parameter int unsigned MAX_PEND = 15,
  localparam int unsigned TMAX    = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME,
  localparam int unsigned PW      = $clog2(MAX_PEND + 1),
  localparam int unsigned TW      = $clog2(TMAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ev,
  input  logic          clr,
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  // The timer holds the cycles left after the current one. Loading N-1 on
  // entry and leaving at zero keeps each state for exactly N cycles.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TIME - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TIME - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            led_d;
  logic            ovf_d;
  logic            deq;

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      led     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led     <= led_d;
      ovf     <= ovf_d;
    end
  end

  // Next state and timer. deq marks the edge where a queued event starts its blink.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deq     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_ON;
          timer_d = ON_LOAD;
          deq     = 1'b1;
        end
      end
      S_ON: begin
        if (timer_q == '0) begin
          state_d = S_OFF;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_OFF: begin
        if (timer_q == '0) begin
          if (pend_q != '0) begin
            // Start the next blink at once, with no IDLE cycle between blinks.
            state_d = S_ON;
            timer_d = ON_LOAD;
            deq     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Pending queue. clr wins over everything and drops a coincident ev. A dequeue
  // on the same edge still starts its blink because deq comes from the FSM.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (clr) begin
      pend_d = '0;
    end else if (ev && !deq) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PW'(1);
      end
    end else if (!ev && deq) begin
      pend_d = pend_q - PW'(1);
    end
  end

  // led is taken from the next state so the pin is a plain flop output.
  always_comb begin
    led_d = (state_d == S_ON);
  end

  assign pending = pend_q;
  assign busy    = (state_q != S_IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_event_blinker.sv
module tb_event_blinker;

  localparam int unsigned ON_T  = 4;
  localparam int unsigned OFF_T = 3;
  localparam int unsigned MAXP  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ev;
  logic       clr;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  event_blinker #(
    .ON_TIME (ON_T),
    .OFF_TIME(OFF_T),
    .MAX_PEND(MAXP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ev     (ev),
    .clr    (clr),
    .led    (led),
    .busy   (busy),
    .pending(pending),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    k;
    string name;
    logic  led;
    logic  busy;
    logic  ovf;
    logic [1:0] pend;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string rep(string c, int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  // Monitor: every cycle compares the DUT outputs with the expected entries
  // for that cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          chk($sformatf("%s e%0d missed", e.name, e.k), 32'(cyc), 32'(e.cyc));
        end else begin
          chk($sformatf("%s e%0d led", e.name, e.k), 32'(led), 32'(e.led));
          chk($sformatf("%s e%0d busy", e.name, e.k), 32'(busy), 32'(e.busy));
          chk($sformatf("%s e%0d ovf", e.name, e.k), 32'(ovf), 32'(e.ovf));
          chk($sformatf("%s e%0d pending", e.name, e.k), 32'(pending), 32'(e.pend));
        end
      end
    end
  end

  // Character k of each string is the stimulus for edge k, or the output
  // expected after edge k. The task is called on a negedge.
  task automatic run_test(string name, string evs, string clrs, string leds,
                          string busys, string ovfs, string pends);
    int   n    = evs.len();
    int   base = cyc;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc  = base + k + 1;
      e.k    = k;
      e.name = name;
      e.led  = (leds[k] == "1");
      e.busy = (busys[k] == "1");
      e.ovf  = (ovfs[k] == "1");
      e.pend = 2'(pends[k] - "0");
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      ev  = (evs[k] == "1");
      clr = (clrs[k] == "1");
      @(negedge clk);
    end
    ev  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ev    = 1'b0;
    clr   = 1'b0;
    #3;
    chk("reset led", 32'(led), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset pending", 32'(pending), 0);
    chk("reset ovf", 32'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single event
    run_test("t1_single", {"1", rep("0", 10)}, rep("0", 11),
             {"01111", rep("0", 6)}, {rep("1", 8), rep("0", 3)},
             rep("0", 11), {"1", rep("0", 10)});

    // 2: three events back-to-back
    run_test("t2_three", {"111", rep("0", 21)}, rep("0", 24),
             {"0", "1111", "000", "1111", "000", "1111", rep("0", 5)},
             {rep("1", 22), "00"}, rep("0", 24),
             {"11", rep("2", 6), rep("1", 7), rep("0", 9)});

    // 3: overflow, saturating queue
    run_test("t3_ovf", {rep("1", 5), rep("0", 27)}, rep("0", 32),
             {"0", "1111", "000", "1111", "000", "1111", "000", "1111", rep("0", 6)},
             {rep("1", 29), "000"}, {"00001", rep("0", 27)},
             {"112", rep("3", 5), rep("2", 7), rep("1", 7), rep("0", 10)});

    // 4: clr with coincident ev during the first ON
    run_test("t4_clr", {"1111", rep("0", 8)}, {"0001", rep("0", 8)},
             {"01111", rep("0", 7)}, {rep("1", 8), rep("0", 4)},
             rep("0", 12), {"112", rep("0", 9)});

    // 5: asynchronous reset in the middle of ON
    run_test("t5_pre", "100", "000", "011", "111", "000", "100");
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async led", 32'(led), 0);
    chk("t5 async busy", 32'(busy), 0);
    chk("t5 async pending", 32'(pending), 0);
    chk("t5 async ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_test("t5_post", rep("0", 10), rep("0", 10), rep("0", 10),
             rep("0", 10), rep("0", 10), rep("0", 10));

    // 6: event queued as the last OFF cycle begins, so the next blink follows directly
    run_test("t6_lastoff", {"10000001", rep("0", 10)}, rep("0", 18),
             {"0", "1111", "000", "1111", rep("0", 6)},
             {rep("1", 15), "000"}, rep("0", 18),
             {"1", rep("0", 6), "1", rep("0", 10)});

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
